// File: rtl/melody_pkg.sv
// Shared melody definitions: note codes, tone half-periods,
// sequencer states and the song ROM contents.
package melody_pkg;

  typedef enum logic [2:0] {
    NOTE_REST,
    NOTE_DO,
    NOTE_RE,
    NOTE_MI,
    NOTE_FA,
    NOTE_SOL,
    NOTE_RA,
    NOTE_SI
  } note_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_TONE,
    S_GAP
  } state_e;

  localparam logic [21:0] HP_DO  = 22'd191_112;
  localparam logic [21:0] HP_RE  = 22'd170_262;
  localparam logic [21:0] HP_MI  = 22'd151_685;
  localparam logic [21:0] HP_FA  = 22'd143_172;
  localparam logic [21:0] HP_SOL = 22'd127_551;
  localparam logic [21:0] HP_RA  = 22'd113_636;
  localparam logic [21:0] HP_SI  = 22'd101_238;

  function automatic logic [21:0] half_period(
    input logic [2:0] code
  );
    logic [21:0] hp;
    hp = '0;
    case (note_e'(code))
      NOTE_DO:  hp = HP_DO;
      NOTE_RE:  hp = HP_RE;
      NOTE_MI:  hp = HP_MI;
      NOTE_FA:  hp = HP_FA;
      NOTE_SOL: hp = HP_SOL;
      NOTE_RA:  hp = HP_RA;
      NOTE_SI:  hp = HP_SI;
      default:  hp = '0;
    endcase
    return hp;
  endfunction

  function automatic logic [5:0] ent(
    input note_e      n,
    input logic [2:0] len
  );
    return {n, len};
  endfunction

  // Song 0 is the default tune; song 1 exercises a rest
  // and the two highest notes. Length 0 ends the song.
  function automatic logic [5:0] song_rom(
    input logic       alt,
    input logic [4:0] idx
  );
    logic [5:0] e;
    e = '0;
    if (alt) begin
      case (idx)
        5'd0:    e = ent(NOTE_REST, 3'd1);
        5'd1:    e = ent(NOTE_RA, 3'd1);
        5'd2:    e = ent(NOTE_SI, 3'd1);
        default: e = '0;
      endcase
    end else begin
      case (idx)
        5'd0:    e = ent(NOTE_DO, 3'd2);
        5'd1:    e = ent(NOTE_RE, 3'd2);
        5'd2:    e = ent(NOTE_MI, 3'd2);
        5'd3:    e = ent(NOTE_FA, 3'd2);
        5'd4:    e = ent(NOTE_SOL, 3'd4);
        default: e = '0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave divider; output toggles every half_period
// cycles while enabled, held at 0 when disabled.
module tone_gen
  import melody_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [21:0] half_period,
  output logic        wave
);

  logic [21:0] cnt;
  logic        wave_q;

  // Count up to half_period-1 then toggle; disabling restarts phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      wave_q <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      wave_q <= 1'b0;
    end else if (cnt >= half_period - 22'd1) begin
      cnt    <= '0;
      wave_q <= ~wave_q;
    end else begin
      cnt <= cnt + 22'd1;
    end
  end

  // Gate with en so the output drops in the same cycle as enable.
  assign wave = wave_q & en;

endmodule

// File: rtl/melody_sequencer.sv
// Song ROM sequencer: plays note/length entries with an
// articulation gap after each note, optional looping.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 2_000_000,
  parameter int SONG_LEN    = 16,
  parameter int SONG_SEL    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic       buzzer,
  output logic       busy,
  output logic [4:0] note_idx,
  output logic       done
);

  localparam logic [26:0] UNIT   = 27'(UNIT_CYCLES);
  localparam logic [26:0] GAP_LD = 27'(GAP_CYCLES - 1);

  state_e      state;
  logic [26:0] dur;
  logic [5:0]  entry;
  logic [2:0]  code;
  logic [2:0]  len;
  logic        at_end;
  logic        tone_en;
  logic [21:0] hp;

  assign entry   = song_rom(SONG_SEL != 0, note_idx);
  assign code    = entry[5:3];
  assign len     = entry[2:0];
  assign at_end  = (len == 3'd0) ||
                   ({1'b0, note_idx} >= 6'(SONG_LEN));
  assign tone_en = (state == S_TONE) && (code != 3'd0);
  assign hp      = half_period(code);
  assign busy    = (state != S_IDLE);

  tone_gen u_tone (
    .clk         (clk),
    .reset       (reset),
    .en          (tone_en),
    .half_period (hp),
    .wave        (buzzer)
  );

  // Sequencer FSM; stop overrides everything and never pulses done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      note_idx <= '0;
      dur      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
        dur   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              note_idx <= '0;
              state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (at_end) begin
              if (loop_en && note_idx != 5'd0) begin
                note_idx <= '0;
              end else begin
                state <= S_IDLE;
                done  <= 1'b1;
              end
            end else begin
              dur   <= 27'(len) * UNIT - 27'd1;
              state <= S_TONE;
            end
          end
          S_TONE: begin
            if (dur == '0) begin
              dur   <= GAP_LD;
              state <= S_GAP;
            end else begin
              dur <= dur - 27'd1;
            end
          end
          S_GAP: begin
            if (dur == '0) begin
              note_idx <= note_idx + 5'd1;
              state    <= S_LOAD;
            end else begin
              dur <= dur - 27'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: default song on one
// instance, rest/RA/SI song on a second instance.
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, loop_en;
  logic       buzzer, busy, done;
  logic [4:0] note_idx;
  logic       r_reset, r_start, r_stop, r_loop_en;
  logic       r_buzzer, r_busy, r_done;
  logic [4:0] r_note_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  melody_sequencer #(
    .UNIT_CYCLES (400_000),
    .GAP_CYCLES  (100),
    .SONG_LEN    (16),
    .SONG_SEL    (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .buzzer   (buzzer),
    .busy     (busy),
    .note_idx (note_idx),
    .done     (done)
  );

  melody_sequencer #(
    .UNIT_CYCLES (400_000),
    .GAP_CYCLES  (100),
    .SONG_LEN    (16),
    .SONG_SEL    (1)
  ) dut_r (
    .clk      (clk),
    .reset    (r_reset),
    .start    (r_start),
    .stop     (r_stop),
    .loop_en  (r_loop_en),
    .buzzer   (r_buzzer),
    .busy     (r_busy),
    .note_idx (r_note_idx),
    .done     (r_done)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; r_reset = 1'b1;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    r_start = 1'b0; r_stop = 1'b0; r_loop_en = 1'b0;
    tick(3);
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (note_idx !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", note_idx); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (r_busy !== 1'b0) begin errors++; $display("FAIL reset_r_busy: got %b want 0", r_busy); end
    reset = 1'b0; r_reset = 1'b0;
    tick(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold_busy: got %b want 0", busy); end
  endtask

  task automatic test_play;
    int cyc, nchg, bad, dcnt, dcyc;
    int rise[5];
    int rise_exp[5] = '{191112, 970363, 1751887, 2543475, 3327955};
    int chg[5];
    int chg_exp[5] = '{800100, 1600201, 2400302, 3200403, 4800504};
    logic pb;
    logic [4:0] pi;
    loop_en = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL play_busy_rise: got %b want 1", busy); end
    checks++; if (note_idx !== 5'd0) begin errors++; $display("FAIL play_idx0: got %0d want 0", note_idx); end
    tick(1);
    cyc = 0; nchg = 0; bad = 0; dcnt = 0; dcyc = -1;
    for (int k = 0; k < 5; k++) begin rise[k] = -1; chg[k] = -1; end
    pb = buzzer; pi = note_idx;
    while (busy === 1'b1 && cyc < 5_000_000) begin
      tick(1); cyc++;
      if (buzzer && !pb && note_idx < 5 && rise[note_idx] < 0) rise[note_idx] = cyc;
      if (note_idx !== pi) begin
        if (note_idx !== pi + 5'd1) bad++;
        if (nchg < 5) chg[nchg] = cyc;
        nchg++;
      end
      if (done === 1'b1) begin dcnt++; dcyc = cyc; end
      pb = buzzer; pi = note_idx;
    end
    for (int k = 0; k < 5; k++) begin
      checks++; if (rise[k] != rise_exp[k]) begin errors++; $display("FAIL play_rise_%0d: got %0d want %0d", k, rise[k], rise_exp[k]); end
      checks++; if (chg[k] != chg_exp[k]) begin errors++; $display("FAIL play_step_%0d: got %0d want %0d", k, chg[k], chg_exp[k]); end
    end
    checks++; if (nchg != 5 || bad != 0) begin errors++; $display("FAIL play_steps: got %0d steps %0d bad want 5 0", nchg, bad); end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL play_done_count: got %0d want 1", dcnt); end
    checks++; if (dcyc != 4800505) begin errors++; $display("FAIL play_done_cyc: got %0d want 4800505", dcyc); end
    checks++; if (cyc != 4800505) begin errors++; $display("FAIL play_busy_fall: got %0d want 4800505", cyc); end
    tick(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL play_done_width: got %b want 0", done); end
  endtask

  task automatic test_loop;
    int cyc, wrap, dcnt, nb, r2;
    logic pb;
    logic [4:0] pi;
    loop_en = 1'b1;
    start = 1'b1; tick(1); start = 1'b0;
    tick(1);
    cyc = 0; wrap = -1; dcnt = 0; nb = 0; r2 = -1;
    pb = buzzer; pi = note_idx;
    while (r2 < 0 && cyc < 5_100_000) begin
      tick(1); cyc++;
      if (pi == 5'd5 && note_idx == 5'd0 && wrap < 0) wrap = cyc;
      if (done === 1'b1) dcnt++;
      if (busy !== 1'b1) nb++;
      if (wrap >= 0 && buzzer && !pb) r2 = cyc;
      pb = buzzer; pi = note_idx;
    end
    checks++; if (wrap != 4800505) begin errors++; $display("FAIL loop_wrap: got %0d want 4800505", wrap); end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL loop_no_done: got %0d want 0", dcnt); end
    checks++; if (nb != 0) begin errors++; $display("FAIL loop_busy_drop: got %0d want 0", nb); end
    checks++; if (r2 != 4991618) begin errors++; $display("FAIL loop_do_replay: got %0d want 4991618", r2); end
    stop = 1'b1; tick(1); stop = 1'b0; loop_en = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop_busy: got %b want 0", busy); end
  endtask

  task automatic test_stop;
    int cyc, dcnt;
    start = 1'b1; tick(1); start = 1'b0;
    tick(1);
    cyc = 0;
    while (note_idx != 5'd2 && cyc < 2_000_000) begin tick(1); cyc++; end
    checks++; if (cyc != 1600201) begin errors++; $display("FAIL stop_reach_idx2: got %0d want 1600201", cyc); end
    tick(300000);
    checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL stop_pre_buzzer: got %b want 1", buzzer); end
    stop = 1'b1; tick(1); stop = 1'b0;
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL stop_buzzer: got %b want 0", buzzer); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy); end
    dcnt = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin tick(1); if (done === 1'b1 || busy === 1'b1) dcnt++; end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL stop_no_done: got %0d want 0", dcnt); end
    start = 1'b1; tick(1); start = 1'b0;
    checks++; if (busy !== 1'b1 || note_idx !== 5'd0) begin errors++; $display("FAIL restart: got busy %b idx %0d want 1 0", busy, note_idx); end
    tick(1);
    cyc = 0;
    while (buzzer !== 1'b1 && cyc < 300000) begin tick(1); cyc++; end
    checks++; if (cyc != 191112) begin errors++; $display("FAIL restart_do_rise: got %0d want 191112", cyc); end
    stop = 1'b1; tick(1); stop = 1'b0;
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_same: got %b want 0", busy); end
  endtask

  task automatic test_rest;
    int cyc, hi, chg, rra, rsi;
    logic pb;
    r_start = 1'b1; tick(1); r_start = 1'b0;
    checks++; if (r_busy !== 1'b1) begin errors++; $display("FAIL rest_busy: got %b want 1", r_busy); end
    tick(1);
    cyc = 0; hi = 0; chg = -1; rra = -1; rsi = -1;
    pb = r_buzzer;
    while (rsi < 0 && cyc < 1_000_000) begin
      r_start = (cyc == 999);
      tick(1); cyc++;
      if (r_buzzer === 1'b1 && cyc <= 400100) hi++;
      if (chg < 0 && r_note_idx == 5'd1) chg = cyc;
      if (r_buzzer && !pb && r_note_idx == 5'd1 && rra < 0) rra = cyc;
      if (r_buzzer && !pb && r_note_idx == 5'd2 && rsi < 0) rsi = cyc;
      pb = r_buzzer;
    end
    r_start = 1'b0;
    checks++; if (hi != 0) begin errors++; $display("FAIL rest_silent: got %0d high cycles want 0", hi); end
    checks++; if (chg != 400100) begin errors++; $display("FAIL rest_len: got %0d want 400100", chg); end
    checks++; if (rra != 513737) begin errors++; $display("FAIL ra_rise: got %0d want 513737", rra); end
    checks++; if (rsi != 901440) begin errors++; $display("FAIL si_rise: got %0d want 901440", rsi); end
    tick(50);
    checks++; if (r_buzzer !== 1'b1) begin errors++; $display("FAIL si_high: got %b want 1", r_buzzer); end
    #2 r_reset = 1'b1;
    #1;
    checks++; if (r_buzzer !== 1'b0) begin errors++; $display("FAIL async_note_buzzer: got %b want 0", r_buzzer); end
    checks++; if (r_busy !== 1'b0 || r_note_idx !== 5'd0) begin errors++; $display("FAIL async_note_state: got busy %b idx %0d want 0 0", r_busy, r_note_idx); end
    tick(1);
    r_reset = 1'b0;
  endtask

  task automatic test_async_reset;
    start = 1'b1; tick(1); start = 1'b0;
    tick(1);
    tick(1600150);
    checks++; if (note_idx !== 5'd1 || busy !== 1'b1 || buzzer !== 1'b0) begin errors++; $display("FAIL gap_pre: got idx %0d busy %b buz %b want 1 1 0", note_idx, busy, buzzer); end
    #2 reset = 1'b1;
    #1;
    checks++; if (note_idx !== 5'd0) begin errors++; $display("FAIL async_gap_idx: got %0d want 0", note_idx); end
    checks++; if (busy !== 1'b0 || buzzer !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_gap_out: got busy %b buz %b done %b want 0 0 0", busy, buzzer, done); end
    tick(2);
    reset = 1'b0;
    tick(1000);
    checks++; if (busy !== 1'b0 || buzzer !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy %b buz %b want 0 0", busy, buzzer); end
    start = 1'b1; tick(1); start = 1'b0;
    checks++; if (busy !== 1'b1 || note_idx !== 5'd0) begin errors++; $display("FAIL post_reset_start: got busy %b idx %0d want 1 0", busy, note_idx); end
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  initial begin
    #(64'd400_000_000);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_play();
    test_loop();
    test_stop();
    test_rest();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
